// File: rtl/memory_stage_pkg.sv
// Shared pipeline types for the MEM stage: access FSM states and the MEM/WB bundle.
package memory_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic              writereg;
    logic [REG_W-1:0]  regdest;
    logic [DATA_W-1:0] wbvalue;
  } mem_wb_t;

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory access FSM: captures a load/store, runs the req/ack handshake, raises the upstream stall.
// Optional MEM_TIMEOUT_EN abandons an access after TIMEOUT_CYCLES unacknowledged cycles and pulses o_err.
module mem_access_fsm #(
  parameter int DATA_W         = 32,
  parameter int REG_W          = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_readmem,
  input  logic              i_writemem,
  input  logic [DATA_W-1:0] i_regb,
  input  logic              i_selwsource,
  input  logic [REG_W-1:0]  i_regdest,
  input  logic              i_writereg,
  input  logic [DATA_W-1:0] i_wbvalue,
  input  logic              i_mem_ack,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_idle,
  output logic              o_start,
  output logic              o_done,
  output logic              o_stall,
  output logic [REG_W-1:0]  o_cap_regdest,
  output logic              o_cap_writereg,
  output logic              o_cap_selwsource,
  output logic              o_err
);
  import memory_stage_pkg::mem_state_t;
  import memory_stage_pkg::IDLE;
  import memory_stage_pkg::ACCESS;

  mem_state_t r_state;
  logic       w_start;
  logic       w_ack;
  logic       w_expire;
  logic       w_finish;

  assign w_start  = (r_state == IDLE) && (i_readmem || i_writemem);
  assign w_ack    = (r_state == ACCESS) && i_mem_ack;
  assign w_finish = w_ack || w_expire;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state          <= IDLE;
      o_mem_req        <= 1'b0;
      o_mem_we         <= 1'b0;
      o_mem_addr       <= '0;
      o_mem_wdata      <= '0;
      o_cap_regdest    <= '0;
      o_cap_writereg   <= 1'b0;
      o_cap_selwsource <= 1'b0;
    end else if (w_start) begin
      r_state          <= ACCESS;
      o_mem_req        <= 1'b1;
      o_mem_we         <= i_writemem;
      o_mem_addr       <= i_wbvalue;
      o_mem_wdata      <= i_regb;
      o_cap_regdest    <= i_regdest;
      // A store never writes back, even when readmem is also set.
      o_cap_writereg   <= i_writereg && !i_writemem;
      o_cap_selwsource <= i_selwsource;
    end else if (w_finish) begin
      r_state   <= IDLE;
      o_mem_req <= 1'b0;
    end
  end

  assign o_idle  = (r_state == IDLE);
  assign o_start = w_start;
  assign o_done  = w_ack;
  assign o_stall = !reset && (w_start || ((r_state == ACCESS) && !w_finish));

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_timeout_cnt;
  logic             r_err;

  // Expiry fires on the TIMEOUT_CYCLES-th unacknowledged ACCESS cycle; an ack that cycle wins.
  assign w_expire = (r_state == ACCESS) && !i_mem_ack &&
                    (r_timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_timeout_cnt <= '0;
      r_err         <= 1'b0;
    end else begin
      r_err <= w_expire;
      if (w_start) begin
        r_timeout_cnt <= '0;
      end else if ((r_state == ACCESS) && !i_mem_ack && !w_expire) begin
        r_timeout_cnt <= r_timeout_cnt + 1'b1;
      end
    end
  end

  assign o_err = r_err;
`else
  assign w_expire = 1'b0;
  assign o_err    = 1'b0;
`endif

endmodule

// File: rtl/memory_stage.sv
// Pipeline MEM stage: pass-through of ALU results or load/store via mem_access_fsm, writeback muxing here.
// Define MEM_TIMEOUT_EN to enable the access timeout and mem_err pulse.
module memory_stage #(
  parameter int DATA_W         = memory_stage_pkg::DATA_W,
  parameter int REG_W          = memory_stage_pkg::REG_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_mem_readmem,
  input  logic              ex_mem_writemem,
  input  logic [DATA_W-1:0] ex_mem_regb,
  input  logic              ex_mem_selwsource,
  input  logic [REG_W-1:0]  ex_mem_regdest,
  input  logic              ex_mem_writereg,
  input  logic [DATA_W-1:0] ex_mem_wbvalue,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_if_stall,
  output logic              mem_wb_writereg,
  output logic [REG_W-1:0]  mem_wb_regdest,
  output logic [DATA_W-1:0] mem_wb_wbvalue,
  output logic              mem_err
);
  import memory_stage_pkg::mem_wb_t;

  logic             w_idle;
  logic             w_start;
  logic             w_done;
  logic [REG_W-1:0] w_cap_regdest;
  logic             w_cap_writereg;
  logic             w_cap_selwsource;
  mem_wb_t          r_mem_wb;

  mem_access_fsm #(
    .DATA_W         (DATA_W),
    .REG_W          (REG_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_access_fsm (
    .clock            (clock),
    .reset            (reset),
    .i_readmem        (ex_mem_readmem),
    .i_writemem       (ex_mem_writemem),
    .i_regb           (ex_mem_regb),
    .i_selwsource     (ex_mem_selwsource),
    .i_regdest        (ex_mem_regdest),
    .i_writereg       (ex_mem_writereg),
    .i_wbvalue        (ex_mem_wbvalue),
    .i_mem_ack        (mem_ack),
    .o_mem_req        (mem_req),
    .o_mem_we         (mem_we),
    .o_mem_addr       (mem_addr),
    .o_mem_wdata      (mem_wdata),
    .o_idle           (w_idle),
    .o_start          (w_start),
    .o_done           (w_done),
    .o_stall          (mem_if_stall),
    .o_cap_regdest    (w_cap_regdest),
    .o_cap_writereg   (w_cap_writereg),
    .o_cap_selwsource (w_cap_selwsource),
    .o_err            (mem_err)
  );

  // Non-memory ops flow straight through; every other cycle issues a bubble unless an access completes.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mem_wb <= '0;
    end else if (w_done) begin
      r_mem_wb.writereg <= w_cap_writereg;
      r_mem_wb.regdest  <= w_cap_regdest;
      r_mem_wb.wbvalue  <= w_cap_selwsource ? mem_rdata : mem_addr;
    end else if (w_idle && !w_start) begin
      r_mem_wb.writereg <= ex_mem_writereg;
      r_mem_wb.regdest  <= ex_mem_regdest;
      r_mem_wb.wbvalue  <= ex_mem_wbvalue;
    end else begin
      r_mem_wb.writereg <= 1'b0;
    end
  end

  assign mem_wb_writereg = r_mem_wb.writereg;
  assign mem_wb_regdest  = r_mem_wb.regdest;
  assign mem_wb_wbvalue  = r_mem_wb.wbvalue;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: vector table for pass-through ops, scoreboard for writebacks,
// hand sequences for load/store/reset/timeout corner cases.
module tb_memory_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_mem_readmem;
  logic        ex_mem_writemem;
  logic [31:0] ex_mem_regb;
  logic        ex_mem_selwsource;
  logic [4:0]  ex_mem_regdest;
  logic        ex_mem_writereg;
  logic [31:0] ex_mem_wbvalue;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_if_stall;
  logic        mem_wb_writereg;
  logic [4:0]  mem_wb_regdest;
  logic [31:0] mem_wb_wbvalue;
  logic        mem_err;

  always #5 clock = ~clock;

  memory_stage u_dut (
    .clock             (clock),
    .reset             (reset),
    .ex_mem_readmem    (ex_mem_readmem),
    .ex_mem_writemem   (ex_mem_writemem),
    .ex_mem_regb       (ex_mem_regb),
    .ex_mem_selwsource (ex_mem_selwsource),
    .ex_mem_regdest    (ex_mem_regdest),
    .ex_mem_writereg   (ex_mem_writereg),
    .ex_mem_wbvalue    (ex_mem_wbvalue),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata),
    .mem_ack           (mem_ack),
    .mem_if_stall      (mem_if_stall),
    .mem_wb_writereg   (mem_wb_writereg),
    .mem_wb_regdest    (mem_wb_regdest),
    .mem_wb_wbvalue    (mem_wb_wbvalue),
    .mem_err           (mem_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        full;   // 0: only writereg is meaningful (store / bubble)
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] val;
  } wb_t;
  wb_t sb_q[$];

  typedef struct {
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        ack;
    logic        exp_wr;
    logic [4:0]  exp_rd;
    logic [31:0] exp_val;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic nop_inputs;
    ex_mem_readmem    = 1'b0;
    ex_mem_writemem   = 1'b0;
    ex_mem_regb       = '0;
    ex_mem_selwsource = 1'b0;
    ex_mem_regdest    = '0;
    ex_mem_writereg   = 1'b0;
    ex_mem_wbvalue    = '0;
  endtask

  task automatic check_wb(input string name);
    wb_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got wr=%0d rd=%0d val=0x%08h required an entry",
               name, mem_wb_writereg, mem_wb_regdest, mem_wb_wbvalue);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_writereg"}, 32'(mem_wb_writereg), 32'(e.wr));
      if (e.full) begin
        chk({name, "_regdest"}, 32'(mem_wb_regdest), 32'(e.rd));
        chk({name, "_wbvalue"}, mem_wb_wbvalue, e.val);
      end
      $display("txn %s: wb wr=%0d rd=%0d val=0x%08h", name, mem_wb_writereg, mem_wb_regdest, mem_wb_wbvalue);
    end
  endtask

  // Full load/store: request cycle, wait_cycles unacked ACCESS cycles, then an ack cycle.
  task automatic mem_op(input string name, input logic rdm, input logic wrm, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic sel, input logic [4:0] rd, input logic wrr,
                        input int wait_cycles, input logic [31:0] rdata, output int stall_cycles);
    logic is_store;
    is_store = wrm;
    ex_mem_readmem    = rdm;
    ex_mem_writemem   = wrm;
    ex_mem_wbvalue    = addr;
    ex_mem_regb       = wdata;
    ex_mem_selwsource = sel;
    ex_mem_regdest    = rd;
    ex_mem_writereg   = wrr;
    #1;
    stall_cycles = 0;
    if (mem_if_stall) stall_cycles++;
    chk({name, "_req_cycle_stall"}, 32'(mem_if_stall), 32'd1);
    tick;
    // Garbage upstream values that the stage must ignore while ACCESS.
    ex_mem_readmem  = 1'b1;
    ex_mem_writemem = 1'b0;
    ex_mem_wbvalue  = 32'h0BAD_0BAD;
    ex_mem_regb     = 32'h0BAD_F00D;
    ex_mem_regdest  = 5'd30;
    for (int k = 0; k < wait_cycles; k++) begin
      chk({name, "_wait_req"}, 32'(mem_req), 32'd1);
      chk({name, "_wait_addr"}, mem_addr, addr);
      chk({name, "_wait_wb_writereg"}, 32'(mem_wb_writereg), 32'd0);
      if (mem_if_stall) stall_cycles++;
      tick;
    end
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    #1;
    chk({name, "_ack_req"}, 32'(mem_req), 32'd1);
    chk({name, "_ack_we"}, 32'(mem_we), 32'(is_store));
    chk({name, "_ack_addr"}, mem_addr, addr);
    if (is_store) chk({name, "_ack_wdata"}, mem_wdata, wdata);
    chk({name, "_ack_stall"}, 32'(mem_if_stall), 32'd0);
    if (is_store) sb_q.push_back('{full: 1'b0, wr: 1'b0, rd: rd, val: 32'h0});
    else          sb_q.push_back('{full: 1'b1, wr: wrr, rd: rd, val: (sel ? rdata : addr)});
    tick;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    nop_inputs();
    check_wb(name);
    chk({name, "_done_req"}, 32'(mem_req), 32'd0);
    chk({name, "_done_err"}, 32'(mem_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;

    vecs[0] = '{1'b1, 5'd5,  32'h0000_1234, 1'b0, 1'b1, 5'd5,  32'h0000_1234};
    vecs[1] = '{1'b0, 5'd0,  32'h0000_0000, 1'b0, 1'b0, 5'd0,  32'h0000_0000};
    vecs[2] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF};
    vecs[3] = '{1'b0, 5'd12, 32'hA5A5_A5A5, 1'b0, 1'b0, 5'd12, 32'hA5A5_A5A5};
    vecs[4] = '{1'b1, 5'd1,  32'h8000_0000, 1'b1, 1'b1, 5'd1,  32'h8000_0000};
    vecs[5] = '{1'b1, 5'd16, 32'h0000_0001, 1'b0, 1'b1, 5'd16, 32'h0000_0001};

    // Reset state, with a load request presented during reset.
    reset     = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    nop_inputs();
    ex_mem_readmem = 1'b1;
    tick;
    tick;
    chk("reset_stall", 32'(mem_if_stall), 32'd0);
    chk("reset_req", 32'(mem_req), 32'd0);
    chk("reset_we", 32'(mem_we), 32'd0);
    chk("reset_addr", mem_addr, 32'd0);
    chk("reset_wdata", mem_wdata, 32'd0);
    chk("reset_wb_writereg", 32'(mem_wb_writereg), 32'd0);
    chk("reset_wb_regdest", 32'(mem_wb_regdest), 32'd0);
    chk("reset_wb_wbvalue", mem_wb_wbvalue, 32'd0);
    chk("reset_err", 32'(mem_err), 32'd0);
    nop_inputs();
    reset = 1'b0;
    tick;

    // Pass-through ops (vector 4 also pulses a stray ack while IDLE).
    for (int i = 0; i < 6; i++) begin
      ex_mem_writereg = vecs[i].wr;
      ex_mem_regdest  = vecs[i].rd;
      ex_mem_wbvalue  = vecs[i].val;
      ex_mem_regb     = 32'h1111_1111;
      mem_ack         = vecs[i].ack;
      mem_rdata       = 32'h5555_5555;
      sb_q.push_back('{full: 1'b1, wr: vecs[i].exp_wr, rd: vecs[i].exp_rd, val: vecs[i].exp_val});
      #1;
      chk($sformatf("alu%0d_stall", i), 32'(mem_if_stall), 32'd0);
      tick;
      mem_ack = 1'b0;
      check_wb($sformatf("alu%0d", i));
      chk($sformatf("alu%0d_req", i), 32'(mem_req), 32'd0);
    end
    nop_inputs();
    tick;

    // Load acked on the 4th ACCESS cycle: stall high 4 cycles.
    mem_op("load", 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 5'd7, 1'b1, 3, 32'hDEAD_BEEF, sc);
    chk("load_stall_cycles", 32'(sc), 32'd4);

    // Store acked immediately; writeback suppressed.
    mem_op("store", 1'b0, 1'b1, 32'h200, 32'hCAFE, 1'b0, 5'd9, 1'b1, 0, 32'h0, sc);
    chk("store_stall_cycles", 32'(sc), 32'd1);

    // readmem and writemem together behave as a store.
    mem_op("both", 1'b1, 1'b1, 32'h300, 32'h1357_9BDF, 1'b1, 5'd4, 1'b1, 0, 32'h2468_ACE0, sc);

    // Load with selwsource=0 writes back the address.
    mem_op("load_sel0", 1'b1, 1'b0, 32'h0000_0444, 32'h0, 1'b0, 5'd11, 1'b1, 1, 32'h9999_9999, sc);

    // Back-to-back load then store, one IDLE cycle between requests.
    mem_op("b2b_load", 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 5'd3, 1'b1, 1, 32'h0123_4567, sc);
    mem_op("b2b_store", 1'b0, 1'b1, 32'h44, 32'h89AB_CDEF, 1'b0, 5'd3, 1'b1, 1, 32'h0, sc);

    // Long wait: indefinite without timeout; with timeout, ack on the expiry cycle still wins.
`ifdef MEM_TIMEOUT_EN
    mem_op("ack_on_expiry", 1'b1, 1'b0, 32'h500, 32'h0, 1'b1, 5'd2, 1'b1, 15, 32'hFACE_B00C, sc);
    chk("ack_on_expiry_stall_cycles", 32'(sc), 32'd16);
`else
    mem_op("long_wait", 1'b1, 1'b0, 32'h500, 32'h0, 1'b1, 5'd2, 1'b1, 20, 32'hFACE_B00C, sc);
    chk("long_wait_stall_cycles", 32'(sc), 32'd21);
`endif

    // Reset mid-ACCESS, late ack afterwards ignored.
    ex_mem_readmem  = 1'b1;
    ex_mem_wbvalue  = 32'h600;
    ex_mem_regdest  = 5'd8;
    ex_mem_writereg = 1'b1;
    ex_mem_selwsource = 1'b1;
    tick;
    nop_inputs();
    chk("rst_mid_req_before", 32'(mem_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_stall", 32'(mem_if_stall), 32'd0);
    tick;
    chk("rst_mid_req", 32'(mem_req), 32'd0);
    chk("rst_mid_addr", mem_addr, 32'd0);
    chk("rst_mid_wb_writereg", 32'(mem_wb_writereg), 32'd0);
    reset = 1'b0;
    tick;
    mem_ack   = 1'b1;
    mem_rdata = 32'h7777_7777;
    #1;
    chk("late_ack_stall", 32'(mem_if_stall), 32'd0);
    tick;
    mem_ack = 1'b0;
    chk("late_ack_req", 32'(mem_req), 32'd0);
    chk("late_ack_wb_writereg", 32'(mem_wb_writereg), 32'd0);
    chk("late_ack_wb_wbvalue", mem_wb_wbvalue, 32'd0);
    chk("late_ack_err", 32'(mem_err), 32'd0);
    $display("txn reset_mid_access: req=%0d wb_wr=%0d", mem_req, mem_wb_writereg);

`ifdef MEM_TIMEOUT_EN
    // No ack: abandon after 16 ACCESS cycles with a one-cycle mem_err pulse.
    ex_mem_readmem  = 1'b1;
    ex_mem_wbvalue  = 32'h700;
    ex_mem_regdest  = 5'd6;
    ex_mem_writereg = 1'b1;
    tick;
    nop_inputs();
    for (int k = 0; k < 16; k++) begin
      chk("timeout_req", 32'(mem_req), 32'd1);
      chk("timeout_err_low", 32'(mem_err), 32'd0);
      chk("timeout_stall", 32'(mem_if_stall), (k < 15) ? 32'd1 : 32'd0);
      tick;
    end
    chk("timeout_err_pulse", 32'(mem_err), 32'd1);
    chk("timeout_req_drop", 32'(mem_req), 32'd0);
    chk("timeout_wb_writereg", 32'(mem_wb_writereg), 32'd0);
    chk("timeout_stall_released", 32'(mem_if_stall), 32'd0);
    tick;
    chk("timeout_err_one_cycle", 32'(mem_err), 32'd0);
    $display("txn timeout: err pulse checked");
`endif

    // Normal operation after all corner cases.
    ex_mem_writereg = 1'b1;
    ex_mem_regdest  = 5'd21;
    ex_mem_wbvalue  = 32'h0BEE_F00D;
    sb_q.push_back('{full: 1'b1, wr: 1'b1, rd: 5'd21, val: 32'h0BEE_F00D});
    tick;
    check_wb("alu_final");
    nop_inputs();

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
